// File: rtl/mux4_scan_ctrl.sv
// Select sequencer and sampler for the 4:1 mux stage: steps s1/s0 through
// channels 0..3, samples y at the end of each dwell and publishes a snapshot.
//
// state | meaning
// IDLE  | selects parked at 00, waiting for start
// SCAN  | stepping channels, counting dwell, capturing y
module mux4_scan_ctrl #(
  parameter int DWELL = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       continuous,
  input  logic       abort,
  input  logic       y,
  output logic       s1,
  output logic       s0,
  output logic       busy,
  output logic [3:0] data,
  output logic       valid
);

  typedef enum logic {IDLE, SCAN} state_t;

  localparam logic [7:0] LAST = 8'(DWELL - 1);

  state_t     state_q, state_d;
  logic [1:0] chan_q, chan_d;
  logic [7:0] cnt_q, cnt_d;
  logic [2:0] shadow_q, shadow_d;
  logic [3:0] data_q, data_d;
  logic       valid_q, valid_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      chan_q   <= 2'd0;
      cnt_q    <= 8'd0;
      shadow_q <= 3'd0;
      data_q   <= 4'd0;
      valid_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      chan_q   <= chan_d;
      cnt_q    <= cnt_d;
      shadow_q <= shadow_d;
      data_q   <= data_d;
      valid_q  <= valid_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    chan_d   = chan_q;
    cnt_d    = cnt_q;
    shadow_d = shadow_q;
    data_d   = data_q;
    valid_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = SCAN;
          chan_d  = 2'd0;
          cnt_d   = 8'd0;
        end
      end
      SCAN: begin
        if (abort) begin
          state_d = IDLE;
          chan_d  = 2'd0;
          cnt_d   = 8'd0;
        end else if (cnt_q == LAST) begin
          cnt_d  = 8'd0;
          chan_d = chan_q + 2'd1;
          case (chan_q)
            2'd0: shadow_d[0] = y;
            2'd1: shadow_d[1] = y;
            2'd2: shadow_d[2] = y;
            default: begin
              // Channel 3 goes straight into the snapshot from live y.
              data_d  = {y, shadow_q};
              valid_d = 1'b1;
              if (!continuous) state_d = IDLE;
            end
          endcase
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: begin
        state_d = IDLE;
        chan_d  = 2'd0;
        cnt_d   = 8'd0;
      end
    endcase
  end

  // Channel register doubles as the select register; it is 00 whenever idle.
  assign s1    = chan_q[1];
  assign s0    = chan_q[0];
  assign busy  = (state_q == SCAN);
  assign data  = data_q;
  assign valid = valid_q;

endmodule

// File: doc/mux4_scan_ctrl.md
Name: mux4_scan_ctrl

Overview:
Upstream select sequencer and downstream sampler for the 4:1 mux stage. It drives the mux select lines s1/s0 through channels 0..3 and holds each channel for a programmable dwell time. At the end of each dwell it samples the mux output y. After all four channels are sampled it presents a 4-bit snapshot word with a one-cycle valid strobe. It supports single-shot and continuous scanning, plus abort.

Parameters:
DWELL, 4, clock cycles each channel is held selected; legal range 2..255; y is sampled on the last cycle of the dwell.

Ports:
clk  input  1  single clock; all state updates on rising edge
rst_n  input  1  asynchronous, active-low reset
start  input  1  begin a scan when idle; ignored while busy
continuous  input  1  sampled at each end of scan: 1 = wrap and rescan, 0 = stop
abort  input  1  terminate the scan in progress
y  input  1  output of the 4:1 mux stage
s1  output  1  mux select MSB (registered)
s0  output  1  mux select LSB (registered)
busy  output  1  high while a scan is in progress
data  output  4  last completed snapshot; bit i = y sampled with channel i selected
valid  output  1  one-cycle pulse when data updates

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE, s1=0, s0=0, busy=0, data=4'b0000, valid=0, channel=0, dwell counter=0, shadow bits=0. Outputs hold these values until the first edge after rst_n rises.
- States:
  - IDLE -> SCAN on start=1 at an edge (E0).
  - SCAN -> IDLE on abort, or at end of scan when continuous=0.
  - SCAN -> SCAN (wrap) at end of scan when continuous=1.
- All outputs are registered. {s1,s0} always equals the current channel index, and is 00 in IDLE.
- At E0: busy<=1, channel<=0, counter<=0, {s1,s0}<=00.
- In SCAN the counter increments every edge. At the edge where counter==DWELL-1:
  - shadow[channel]<=y, counter<=0, channel<=channel+1 (mod 4).
  - This gives captures of ch0..ch3 at E0+DWELL, E0+2*DWELL, E0+3*DWELL and E0+4*DWELL.
- End of scan (the ch3 capture edge):
  - data<={y, shadow[2], shadow[1], shadow[0]}, using live y for bit 3.
  - valid<=1 for exactly one cycle; it is 0 at all other times.
  - continuous=1: channel wraps to 00 and scanning continues; the next valid arrives 4*DWELL cycles later.
  - continuous=0: state<=IDLE, busy<=0, {s1,s0}<=00.
- abort=1 in SCAN:
  - Next edge: IDLE, busy=0, {s1,s0}=00, counter=0.
  - No valid pulse; data keeps its previous snapshot.
  - abort wins over a same-edge capture or end of scan.
  - abort in IDLE has no effect.
- start=1 in SCAN is ignored, including at the end-of-scan edge with continuous=0. A new scan needs start asserted while in IDLE.
- start=1 and abort=1 together in IDLE: start is taken (abort applies only in SCAN).
- Reset mid-scan: immediate return to reset values. The partial shadow is discarded and data is cleared to 0.
- Counter is 8 bits wide. For DWELL<2 the behaviour is undefined.

Test Plan:
- Reset: rst_n=0 asserted asynchronously mid-cycle -> s1=s0=busy=valid=0 and data=0000 immediately, without waiting for an edge.
- Single scan, DWELL=4, mux inputs i0=1, i1=1, i2=0, i3=0, start pulsed at E0:
  - {s1,s0} = 00,01,10,11, each held 4 cycles.
  - At E16: data=4'b0011, valid=1 for one cycle, busy=0, selects back to 00.
- Continuous: same inputs with continuous=1; flip i3 to 1 during the second scan.
  - valid at E16 with data=0011.
  - valid at E32 with data=1011.
  - busy stays 1 throughout.
- Abort at E10 during a scan that already has data=0011 -> at E11 busy=0 and selects=00; no valid pulse; data stays 0011.
- Abort asserted exactly on the E16 end-of-scan edge -> no valid pulse and data unchanged. Also: start held high during a scan produces no restart, and the sequence timing is unchanged.
- Reset asserted at E7 of a scan, then released and start given -> data=0000 after reset; the new scan's valid arrives 16 cycles after the new start.
